// File: rtl/alu_bist_controller.sv
// alu_bist_controller
//   Built-in self-test driver for a combinational 32-bit ALU. For each
//   operand vector it walks the enabled opcodes, holds each one for
//   SETTLE_CYCLES+1 cycles, and folds {Result, flagC, flagZ} into a 64-bit
//   MISR on the last of those cycles. When the run ends, the signature is
//   compared against exp_sig.
//
//   Optional macro ALU_BIST_OPMASK_EN adds op_mask[15:0]. It is sampled on
//   start, and opcodes whose mask bit is 0 are skipped.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               run request (honoured in IDLE/DONE only)
//   seed_a, seed_b      first operand vector
//   exp_sig             golden signature
//   operand1/2, opcode  registered drive into the ALU
//   alu_result/flagC/Z  ALU response
//   busy, done, pass    run status (pass only meaningful while done)
//   signature           MISR contents
//   op_mask             opcode enable mask (ALU_BIST_OPMASK_EN only)

module alu_bist_controller #(
  parameter int DATA_W        = 32,
  parameter int RES_W         = 64,
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] seed_a,
  input  logic [DATA_W-1:0] seed_b,
  input  logic [RES_W-1:0]  exp_sig,
  output logic [DATA_W-1:0] operand1,
  output logic [DATA_W-1:0] operand2,
  output logic [3:0]        opcode,
  input  logic [RES_W-1:0]  alu_result,
  input  logic              alu_flagC,
  input  logic              alu_flagZ,
`ifdef ALU_BIST_OPMASK_EN
  input  logic [15:0]       op_mask,
`endif
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [RES_W-1:0]  signature
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DONE} state_t;

  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0]        PASS_LAST   = 8'(PASSES - 1);
  localparam logic [DATA_W-1:0] LFSR_POLY   = DATA_W'(32'h80200003);
  localparam logic [RES_W-1:0]  MISR_POLY   = RES_W'(64'h1B);

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_op1, r_op2, w_op1_nxt, w_op2_nxt;
  logic [3:0]          r_opcode, w_opcode_nxt;
  logic [RES_W-1:0]    r_sig, w_sig_nxt, w_misr;
  logic [7:0]          r_pass_cnt, w_pass_cnt_nxt;
  logic [3:0]          r_settle, w_settle_nxt;
  logic [15:0]         w_start_mask, w_mask;
  logic [4:0]          w_next_en;

  // Mask seen at start (w_start_mask) and mask in force for the run (w_mask).
  // Without the option both are all-ones, so the skip logic folds away.
`ifdef ALU_BIST_OPMASK_EN
  logic [15:0] r_mask;
  assign w_start_mask = op_mask;
  assign w_mask       = r_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                r_mask <= '0;
    else if (start && (r_state == S_IDLE || r_state == S_DONE)) r_mask <= op_mask;
  end
`else
  assign w_start_mask = 16'hFFFF;
  assign w_mask       = 16'hFFFF;
`endif

  // Lowest enabled opcode; meaningless when the mask is zero.
  function automatic logic [3:0] first_en(input logic [15:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) if (m[i]) r = 4'(i);
    return r;
  endfunction

  // {found, index} of the next enabled opcode strictly above cur.
  function automatic logic [4:0] next_en(input logic [15:0] m, input logic [3:0] cur);
    logic [4:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--)
      if (m[i] && (i > int'(cur))) r = {1'b1, 4'(i)};
    return r;
  endfunction

  // Galois shift-right LFSR. The all-zero state is mapped to 1 so that a
  // zero seed cannot lock the operand sequence.
  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] x);
    if (x == '0) return DATA_W'(1);
    return (x >> 1) ^ (x[0] ? LFSR_POLY : '0);
  endfunction

  assign w_misr = ({r_sig[RES_W-2:0], 1'b0} ^ (r_sig[RES_W-1] ? MISR_POLY : '0))
                ^ (alu_result ^ {{(RES_W-2){1'b0}}, alu_flagC, alu_flagZ});

  assign w_next_en = next_en(w_mask, r_opcode);

  always_comb begin
    w_state_nxt    = r_state;
    w_op1_nxt      = r_op1;
    w_op2_nxt      = r_op2;
    w_opcode_nxt   = r_opcode;
    w_sig_nxt      = r_sig;
    w_pass_cnt_nxt = r_pass_cnt;
    w_settle_nxt   = r_settle;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_op1_nxt      = seed_a;
          w_op2_nxt      = seed_b;
          w_opcode_nxt   = first_en(w_start_mask);
          w_sig_nxt      = '0;
          w_pass_cnt_nxt = '0;
          w_settle_nxt   = '0;
          // An empty mask has nothing to test: finish immediately.
          w_state_nxt    = (w_start_mask == 16'h0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_settle == SETTLE_LAST) begin
          w_settle_nxt = '0;
          w_state_nxt  = S_CAPTURE;
        end else begin
          w_settle_nxt = r_settle + 4'd1;
        end
      end
      S_CAPTURE: begin
        w_sig_nxt = w_misr;
        if (w_next_en[4]) begin
          w_opcode_nxt = w_next_en[3:0];
          w_state_nxt  = S_WAIT;
        end else if (r_pass_cnt == PASS_LAST) begin
          w_state_nxt  = S_DONE;
        end else begin
          w_opcode_nxt   = first_en(w_mask);
          w_op1_nxt      = lfsr_step(r_op1);
          w_op2_nxt      = lfsr_step(r_op2);
          w_pass_cnt_nxt = r_pass_cnt + 8'd1;
          w_state_nxt    = S_WAIT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op1      <= '0;
      r_op2      <= '0;
      r_opcode   <= '0;
      r_sig      <= '0;
      r_pass_cnt <= '0;
      r_settle   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_op1      <= w_op1_nxt;
      r_op2      <= w_op2_nxt;
      r_opcode   <= w_opcode_nxt;
      r_sig      <= w_sig_nxt;
      r_pass_cnt <= w_pass_cnt_nxt;
      r_settle   <= w_settle_nxt;
    end
  end

  assign operand1  = r_op1;
  assign operand2  = r_op2;
  assign opcode    = r_opcode;
  assign signature = r_sig;
  assign busy      = (r_state == S_WAIT) || (r_state == S_CAPTURE);
  assign done      = (r_state == S_DONE);
  assign pass      = (r_state == S_DONE) && (r_sig == exp_sig);

endmodule

// File: tb/tb_alu_bist_controller.sv
module tb_alu_bist_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] seed_a = 32'h12345678;
  logic [31:0] seed_b = 32'h9ABCDEF0;
  logic [63:0] exp_sig = '0;
  logic        stub_mode = 1'b0;  // 0: constant ALU response, 1: operand-dependent
  logic [63:0] c_res = '0;
  logic        c_c = 1'b0, c_z = 1'b0;
`ifdef ALU_BIST_OPMASK_EN
  logic [15:0] op_mask = 16'hFFFF;
`endif

  logic [31:0] d1_op1, d1_op2, d2_op1, d2_op2;
  logic [3:0]  d1_opc, d2_opc;
  logic        d1_busy, d1_done, d1_pass, d2_busy, d2_done, d2_pass;
  logic [63:0] d1_sig, d2_sig, res1, res2;
  logic        fc1, fz1, fc2, fz2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stub ALU: either constants, or {operand2, operand1} ^ opcode with flagZ = opcode[0].
  assign res1 = stub_mode ? ({d1_op2, d1_op1} ^ {60'b0, d1_opc}) : c_res;
  assign fc1  = stub_mode ? 1'b0 : c_c;
  assign fz1  = stub_mode ? d1_opc[0] : c_z;
  assign res2 = stub_mode ? ({d2_op2, d2_op1} ^ {60'b0, d2_opc}) : c_res;
  assign fc2  = stub_mode ? 1'b0 : c_c;
  assign fz2  = stub_mode ? d2_opc[0] : c_z;

  alu_bist_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_a(seed_a), .seed_b(seed_b),
    .exp_sig(exp_sig), .operand1(d1_op1), .operand2(d1_op2), .opcode(d1_opc),
    .alu_result(res1), .alu_flagC(fc1), .alu_flagZ(fz1),
`ifdef ALU_BIST_OPMASK_EN
    .op_mask(op_mask),
`endif
    .busy(d1_busy), .done(d1_done), .pass(d1_pass), .signature(d1_sig)
  );

  alu_bist_controller #(.PASSES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_a(seed_a), .seed_b(seed_b),
    .exp_sig(exp_sig), .operand1(d2_op1), .operand2(d2_op2), .opcode(d2_opc),
    .alu_result(res2), .alu_flagC(fc2), .alu_flagZ(fz2),
`ifdef ALU_BIST_OPMASK_EN
    .op_mask(op_mask),
`endif
    .busy(d2_busy), .done(d2_done), .pass(d2_pass), .signature(d2_sig)
  );

  function automatic logic [31:0] lfsr(input logic [31:0] x);
    if (x == 32'h0) return 32'h1;
    if (x[0]) return (x >> 1) ^ 32'h80200003;
    return x >> 1;
  endfunction

  // Reference signature for stub_mode 1.
  function automatic logic [63:0] model_sig(input logic [31:0] a0, input logic [31:0] b0,
                                            input int passes);
    logic [63:0] s, d;
    logic [31:0] a, b;
    logic [3:0]  ov;
    s = '0; a = a0; b = b0;
    for (int p = 0; p < passes; p++) begin
      for (int o = 0; o < 16; o++) begin
        ov = 4'(o);
        d  = ({b, a} ^ {60'b0, ov}) ^ {62'b0, 1'b0, ov[0]};
        s  = ({s[62:0], 1'b0} ^ (s[63] ? 64'h1B : 64'h0)) ^ d;
      end
      a = lfsr(a); b = lfsr(b);
    end
    return s;
  endfunction

  // Pulse start for one sampling edge; returns 1 µs... i.e. after edge t0 + #1.
  task automatic launch();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((d1_busy || d2_busy) && n < 300) begin @(posedge clk); #1; n++; end
    checks++;
    if (d1_busy || d2_busy) begin
      errors++; $display("FAIL wait_idle: busy1=%0b busy2=%0b after %0d cycles", d1_busy, d2_busy, n);
    end
  endtask

  task automatic wait_d1_done(output int cyc);
    cyc = 1;
    while (!d1_done && cyc < 200) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({d1_busy, d1_done, d1_pass} !== 3'b000 || d1_sig !== 64'h0 || d1_op1 !== 32'h0 ||
        d1_op2 !== 32'h0 || d1_opc !== 4'h0) begin
      errors++; $display("FAIL reset_state: busy/done/pass=%b%b%b sig=%h op1=%h op2=%h opc=%h",
                         d1_busy, d1_done, d1_pass, d1_sig, d1_op1, d1_op2, d1_opc);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_zero_sweep();
    int cyc;
    stub_mode = 1'b0; c_res = '0; c_c = 1'b0; c_z = 1'b0; exp_sig = '0;
    wait_idle();
    launch();
    cyc = 1;
    while (!d1_done && cyc < 200) begin
      checks++;
      if (d1_opc !== 4'((cyc - 1) / 2) || d1_busy !== 1'b1) begin
        errors++; $display("FAIL opcode_step c%0d: opc=%0d busy=%b want opc=%0d busy=1",
                           cyc, d1_opc, d1_busy, (cyc - 1) / 2);
      end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc !== 33) begin errors++; $display("FAIL done_latency: got %0d want 33", cyc); end
    checks++;
    if (d1_sig !== 64'h0 || d1_pass !== 1'b1 || d1_busy !== 1'b0) begin
      errors++; $display("FAIL zero_sig: sig=%h pass=%b busy=%b want 0/1/0", d1_sig, d1_pass, d1_busy);
    end
  endtask

  task automatic test_misr_const();
    int cyc;
    stub_mode = 1'b0;
    // {result, flagC, flagZ, exp_sig, expected signature, expected pass}
    for (int k = 0; k < 4; k++) begin
      logic [63:0] r, e, want;
      logic        fc, fz, wp;
      case (k)
        0: begin r = 64'h1; fc = 0; fz = 0; e = 64'hFFFF;  want = 64'hFFFF;  wp = 1; end
        1: begin r = 64'h0; fc = 0; fz = 1; e = 64'hFFFF;  want = 64'hFFFF;  wp = 1; end
        2: begin r = 64'h1; fc = 0; fz = 0; e = 64'h1;     want = 64'hFFFF;  wp = 0; end
        default: begin r = 64'h0; fc = 1; fz = 0; e = 64'h1FFFE; want = 64'h1FFFE; wp = 1; end
      endcase
      c_res = r; c_c = fc; c_z = fz; exp_sig = e;
      wait_idle();
      launch();
      wait_d1_done(cyc);
      checks++;
      if (d1_done !== 1'b1 || d1_sig !== want || d1_pass !== wp) begin
        errors++; $display("FAIL misr_const%0d: done=%b sig=%h pass=%b want sig=%h pass=%b",
                           k, d1_done, d1_sig, d1_pass, want, wp);
      end
    end
  endtask

  task automatic test_two_pass();
    int cyc;
    logic [63:0] want;
    stub_mode = 1'b1;
    seed_a = 32'hABCDABCD; seed_b = 32'h83635273;
    want = model_sig(32'hABCDABCD, 32'h83635273, 2);
    exp_sig = want;
    wait_idle();
    launch();
    cyc = 1;
    while (!d2_done && cyc < 200) begin
      if (cyc == 1 || cyc == 32) begin
        checks++;
        if (d2_op1 !== 32'hABCDABCD || d2_op2 !== 32'h83635273) begin
          errors++; $display("FAIL seed_hold c%0d: op1=%h op2=%h", cyc, d2_op1, d2_op2);
        end
      end
      if (cyc == 33) begin
        checks++;
        if (d2_op1 !== 32'hD5C6D5E5 || d2_op2 !== 32'hC191A93A || d2_opc !== 4'h0) begin
          errors++; $display("FAIL lfsr_step: op1=%h op2=%h opc=%h want D5C6D5E5 C191A93A 0",
                             d2_op1, d2_op2, d2_opc);
        end
      end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc !== 65) begin errors++; $display("FAIL two_pass_latency: got %0d want 65", cyc); end
    checks++;
    if (d2_sig !== want || d2_pass !== 1'b1) begin
      errors++; $display("FAIL two_pass_sig: sig=%h pass=%b want %h/1", d2_sig, d2_pass, want);
    end
    checks++;
    if (d2_op1 !== 32'hD5C6D5E5 || d2_opc !== 4'hF) begin
      errors++; $display("FAIL done_hold: op1=%h opc=%h want D5C6D5E5/F", d2_op1, d2_opc);
    end
  endtask

  task automatic test_start_ignore_and_abort();
    int cyc;
    stub_mode = 1'b0; c_res = 64'h1; c_c = 0; c_z = 0; exp_sig = 64'hFFFF;
    seed_a = 32'h0F0F0001; seed_b = 32'h00A0000B;
    wait_idle();
    launch();
    cyc = 1;
    while (!d1_done && cyc < 200) begin
      if (cyc == 10) start = 1'b1;
      if (cyc == 11) start = 1'b0;
      @(posedge clk); #1; cyc++;
    end
    start = 1'b0;
    checks++;
    if (cyc !== 33 || d1_sig !== 64'hFFFF) begin
      errors++; $display("FAIL start_ignored: done at %0d sig=%h want 33/FFFF", cyc, d1_sig);
    end
    wait_idle();
    launch();
    for (int i = 1; i < 12; i++) begin @(posedge clk); #1; end
    #2; rst_n = 1'b0; #1;
    checks++;
    if ({d1_busy, d1_done, d1_pass, d2_busy, d2_done, d2_pass} !== 6'b0 || d1_sig !== 64'h0 ||
        d1_op1 !== 32'h0 || d1_op2 !== 32'h0 || d1_opc !== 4'h0 || d2_op1 !== 32'h0) begin
      errors++; $display("FAIL async_abort: b/d/p=%b%b%b sig=%h op1=%h op2=%h opc=%h",
                         d1_busy, d1_done, d1_pass, d1_sig, d1_op1, d1_op2, d1_opc);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (d1_done !== 1'b0 || d1_busy !== 1'b0) begin
      errors++; $display("FAIL abort_idle: done=%b busy=%b want 0/0", d1_done, d1_busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    stub_mode = 1'b0; c_res = 64'h1; exp_sig = 64'hFFFF;
    wait_idle();
    launch();
    wait_d1_done(cyc);
    // Hold start high from DONE: relaunch, stay busy, finish, relaunch again.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (d1_busy !== 1'b1 || d1_done !== 1'b0 || d1_sig !== 64'h0 || d1_opc !== 4'h0) begin
      errors++; $display("FAIL relaunch: busy=%b done=%b sig=%h opc=%h", d1_busy, d1_done, d1_sig, d1_opc);
    end
    wait_d1_done(cyc);
    checks++;
    if (cyc !== 33 || d1_sig !== 64'hFFFF) begin
      errors++; $display("FAIL held_start_run: done at %0d sig=%h want 33/FFFF", cyc, d1_sig);
    end
    @(posedge clk); #1;
    checks++;
    if (d1_busy !== 1'b1 || d1_done !== 1'b0) begin
      errors++; $display("FAIL relaunch2: busy=%b done=%b want 1/0", d1_busy, d1_done);
    end
    start = 1'b0;
    wait_d1_done(cyc);
  endtask

`ifdef ALU_BIST_OPMASK_EN
  task automatic test_opmask();
    int cyc;
    logic [3:0] seq [4];
    seq[0] = 4'd0; seq[1] = 4'd0; seq[2] = 4'd2; seq[3] = 4'd2;
    stub_mode = 1'b0; c_res = 64'h1; exp_sig = 64'h3;
    wait_idle();
    op_mask = 16'h0005;
    launch();
    cyc = 1;
    while (!d1_done && cyc < 200) begin
      if (cyc <= 4) begin
        checks++;
        if (d1_opc !== seq[cyc-1]) begin
          errors++; $display("FAIL mask_seq c%0d: opc=%0d want %0d", cyc, d1_opc, seq[cyc-1]);
        end
      end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc !== 5 || d1_sig !== 64'h3 || d1_pass !== 1'b1) begin
      errors++; $display("FAIL mask_run: done at %0d sig=%h pass=%b want 5/3/1", cyc, d1_sig, d1_pass);
    end
    wait_idle();
    op_mask = 16'h0000; exp_sig = 64'h0;
    launch();
    checks++;
    if (d1_done !== 1'b1 || d1_sig !== 64'h0 || d1_pass !== 1'b1) begin
      errors++; $display("FAIL mask_zero: done=%b sig=%h pass=%b want 1/0/1", d1_done, d1_sig, d1_pass);
    end
    op_mask = 16'hFFFF;
  endtask
`endif

  initial begin
    test_reset();
    test_zero_sweep();
    test_misr_const();
    test_two_pass();
    test_start_ignore_and_abort();
    test_back_to_back();
`ifdef ALU_BIST_OPMASK_EN
    test_opmask();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute watchdog so the run can never hang.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
